// File: rtl/cpu_fetch_q.sv
// Instruction fetch with static JAL/backward-branch prediction feeding a QDEPTH-entry decoupling queue.
// Latency: a hit in cycle N is on dq_*0 in N+1 (empty queue); a redirect in N gives ic_pc=target in N+1.
// Backpressure: ic_req drops when the queue stays full after this cycle's pops, during a JALR stall, or when rdy=0.
module cpu_fetch_q #(
    parameter int                ADDR_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_pc,
    input  logic              ic_hit,
    input  logic [31:0]       ic_inst,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_pc,
    output logic              dq_valid0,
    output logic              dq_valid1,
    output logic [ADDR_W-1:0] dq_pc0,
    output logic [ADDR_W-1:0] dq_pc1,
    output logic [31:0]       dq_inst0,
    output logic [31:0]       dq_inst1,
    output logic              dq_pred0,
    output logic              dq_pred1,
    input  logic [1:0]        issue_cnt
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [ADDR_W-1:0] r_pc;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_jalr_stall;

    logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
    logic [31:0]       r_q_inst [QDEPTH];
    logic              r_q_pred [QDEPTH];

    logic [31:0]       w_inst;
    logic [ADDR_W-1:0] w_j_off;
    logic [ADDR_W-1:0] w_b_off;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_npc;
    logic              w_pred;
    logic              w_is_jalr;
    logic [1:0]        w_iss;
    logic [CW-1:0]     w_iss_ext;
    logic [CW-1:0]     w_pop;
    logic              w_full_eff;
    logic              w_redir;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_enq;
    logic [PW-1:0]     w_head1;

    // Cache delivers the word byte-reversed; everything downstream sees natural order.
    assign w_inst   = {ic_inst[7:0], ic_inst[15:8], ic_inst[23:16], ic_inst[31:24]};
    assign w_j_off  = {{(ADDR_W-21){w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_b_off  = {{(ADDR_W-13){w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_pc_seq = r_pc + ADDR_W'(4);

    // Static predictor: JAL always taken, branches taken when the offset sign bit is set.
    always_comb begin
        w_pred    = 1'b0;
        w_npc     = w_pc_seq;
        w_is_jalr = 1'b0;
        case (w_inst[6:0])
            OP_JAL: begin
                w_pred = 1'b1;
                w_npc  = r_pc + w_j_off;
            end
            OP_BR: begin
                w_pred = w_inst[31];
                if (w_inst[31]) w_npc = r_pc + w_b_off;
            end
            OP_JALR: begin
                w_is_jalr = (w_inst[14:12] == 3'b000);
            end
            default: ;
        endcase
    end

    // A value of 3 has no decoder port behind it, so it is treated as 2; over-issue saturates at occupancy.
    assign w_iss      = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign w_iss_ext  = CW'(w_iss);
    assign w_pop      = !rdy ? '0 : ((w_iss_ext > r_count) ? r_count : w_iss_ext);
    assign w_full_eff = ((r_count - w_pop) == CW'(QDEPTH));

    assign ic_req  = rdy & ~r_jalr_stall & ~w_full_eff;
    assign ic_pc   = r_pc;
    assign w_redir = rdy & (br_valid | jmp_valid);
    assign w_tgt   = br_valid ? br_pc : jmp_pc;
    assign w_enq   = ic_req & ic_hit & ~w_redir;

    // PC, pointers, occupancy and JALR stall; a redirect discards this cycle's enqueue and pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_jalr_stall <= 1'b0;
        end else if (rdy) begin
            if (w_redir) begin
                r_pc         <= w_tgt;
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_jalr_stall <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_pc <= w_npc;
                    if (w_is_jalr) r_jalr_stall <= 1'b1;
                end
                r_head  <= r_head + w_pop[PW-1:0];
                r_tail  <= r_tail + PW'(w_enq);
                r_count <= r_count - w_pop + CW'(w_enq);
            end
        end
    end

    // Entry storage, written at the tail on each accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
                r_q_pred[i] <= 1'b0;
            end
        end else if (w_enq) begin
            r_q_pc[r_tail]   <= r_pc;
            r_q_inst[r_tail] <= w_inst;
            r_q_pred[r_tail] <= w_pred;
        end
    end

    assign w_head1   = r_head + PW'(1);
    assign dq_valid0 = (r_count >= CW'(1));
    assign dq_valid1 = (r_count >= CW'(2));
    assign dq_pc0    = r_q_pc[r_head];
    assign dq_pc1    = r_q_pc[w_head1];
    assign dq_inst0  = r_q_inst[r_head];
    assign dq_inst1  = r_q_inst[w_head1];
    assign dq_pred0  = r_q_pred[r_head];
    assign dq_pred1  = r_q_pred[w_head1];
endmodule

// File: tb/tb_cpu_fetch_q.sv
// Bench for cpu_fetch_q: directed scenarios plus a scoreboarded random stream.
// Inputs change 1 time unit after posedge; outputs are sampled away from the edge.
// Every wait is a clock edge; a watchdog bounds total run time.
module tb_cpu_fetch_q;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        ic_req;
    logic [31:0] ic_pc;
    logic        ic_hit = 1'b0;
    logic [31:0] ic_inst = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_pc = '0;
    logic        dq_valid0, dq_valid1;
    logic [31:0] dq_pc0, dq_pc1, dq_inst0, dq_inst1;
    logic        dq_pred0, dq_pred1;
    logic [1:0]  issue_cnt = 2'd0;

    cpu_fetch_q #(.ADDR_W(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .ic_req(ic_req), .ic_pc(ic_pc),
        .ic_hit(ic_hit), .ic_inst(ic_inst), .br_valid(br_valid), .br_pc(br_pc),
        .jmp_valid(jmp_valid), .jmp_pc(jmp_pc), .dq_valid0(dq_valid0), .dq_valid1(dq_valid1),
        .dq_pc0(dq_pc0), .dq_pc1(dq_pc1), .dq_inst0(dq_inst0), .dq_inst1(dq_inst1),
        .dq_pred0(dq_pred0), .dq_pred1(dq_pred1), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic        s_req;
    logic [31:0] s_pc;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jalr();
        return {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
    endfunction

    // One fetch cycle: drive, sample request/PC before the edge, update scoreboard at the edge.
    task automatic drive(input logic hit, input logic [31:0] w, input logic [1:0] iss,
                         input logic enq, input logic [31:0] pc, input logic pred);
        ent_t e;
        ic_hit = hit; ic_inst = bswap(w); issue_cnt = iss;
        #2;
        s_req = ic_req; s_pc = ic_pc;
        @(posedge clk);
        repeat (int'(iss)) if (sb.size() > 0) void'(sb.pop_front());
        if (enq) begin
            e.pc = pc; e.inst = w; e.pred = pred;
            sb.push_back(e);
        end
        #1;
        ic_hit = 1'b0; issue_cnt = 2'd0;
    endtask

    // One redirect cycle with a competing fetch hit and issue that must both be discarded.
    task automatic redir(input logic bv, input logic [31:0] bp, input logic jv, input logic [31:0] jp);
        br_valid = bv; br_pc = bp; jmp_valid = jv; jmp_pc = jp;
        ic_hit = 1'b1; ic_inst = bswap(enc_addi(12'd7)); issue_cnt = 2'd1;
        #2;
        @(posedge clk);
        sb.delete();
        #1;
        br_valid = 1'b0; jmp_valid = 1'b0; ic_hit = 1'b0; issue_cnt = 2'd0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (ic_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b want=1", ic_req); end
        total++; if (ic_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", ic_pc); end
        total++; if ({dq_valid0, dq_valid1} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {dq_valid0, dq_valid1}); end
        total++; if ({dq_pc0, dq_inst0, dq_pred0} !== 65'h0) begin bad++; $display("FAIL reset_entry got=%h/%h/%b want=0", dq_pc0, dq_inst0, dq_pred0); end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        drive(1'b1, enc_addi(12'd1), 2'd0, 1'b1, 32'h0, 1'b0);
        total++; if (dq_valid0 !== 1'b1 || dq_pc0 !== 32'h0) begin bad++; $display("FAIL basic_first got=%b/%h want=1/0", dq_valid0, dq_pc0); end
        total++; if (dq_inst0 !== enc_addi(12'd1)) begin bad++; $display("FAIL basic_swap got=%h want=%h", dq_inst0, enc_addi(12'd1)); end
        drive(1'b1, enc_addi(12'd2), 2'd0, 1'b1, 32'h4, 1'b0);
        drive(1'b1, enc_addi(12'd3), 2'd0, 1'b1, 32'h8, 1'b0);
        total++; if (dq_valid1 !== 1'b1 || dq_pc1 !== 32'h4) begin bad++; $display("FAIL basic_second got=%b/%h want=1/4", dq_valid1, dq_pc1); end
        total++; if (ic_pc !== 32'hC) begin bad++; $display("FAIL basic_pc got=%h want=c", ic_pc); end
        drive(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        total++; if (dq_pc0 !== sb[0].pc || sb.size() != 1) begin bad++; $display("FAIL basic_pop2 got=%h want=%h", dq_pc0, sb[0].pc); end
        drive(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        total++; if (dq_valid0 !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", dq_valid0); end
    endtask

    task automatic test_full();
        redir(1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, enc_addi(12'(i)), 2'd0, 1'b1, 32'(4*i), 1'b0);
        total++; if (ic_req !== 1'b0 || ic_pc !== 32'h10) begin bad++; $display("FAIL full_stop got=%b/%h want=0/10", ic_req, ic_pc); end
        drive(1'b1, enc_addi(12'd9), 2'd1, 1'b1, 32'h10, 1'b0);
        total++; if (s_req !== 1'b1) begin bad++; $display("FAIL full_popfree got=%b want=1", s_req); end
        total++; if (dq_pc0 !== 32'h4 || ic_pc !== 32'h14) begin bad++; $display("FAIL full_enq got=%h/%h want=4/14", dq_pc0, ic_pc); end
        drive(1'b1, enc_addi(12'd9), 2'd0, 1'b0, 32'h0, 1'b0);
        total++; if (s_req !== 1'b0 || ic_pc !== 32'h14) begin bad++; $display("FAIL full_hold got=%b/%h want=0/14", s_req, ic_pc); end
        drive(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        total++; if (dq_valid0 !== 1'b0 || ic_pc !== 32'h14 || ic_req !== 1'b1) begin bad++; $display("FAIL full_miss got=%b/%h/%b want=0/14/1", dq_valid0, ic_pc, ic_req); end
    endtask

    task automatic test_predict();
        redir(1'b1, 32'h8, 1'b0, 32'h0);
        total++; if (ic_pc !== 32'h8) begin bad++; $display("FAIL redir_latency got=%h want=8", ic_pc); end
        drive(1'b1, enc_jal(21'h100), 2'd0, 1'b1, 32'h8, 1'b1);
        total++; if (ic_pc !== 32'h108) begin bad++; $display("FAIL jal_target got=%h want=108", ic_pc); end
        total++; if (dq_pred0 !== sb[0].pred || dq_pc0 !== sb[0].pc || dq_inst0 !== sb[0].inst) begin bad++; $display("FAIL jal_entry got=%b/%h/%h want=1/8/%h", dq_pred0, dq_pc0, dq_inst0, sb[0].inst); end
        redir(1'b1, 32'h20, 1'b0, 32'h0);
        total++; if (dq_valid0 !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", dq_valid0); end
        drive(1'b1, enc_b(13'h1FF8), 2'd0, 1'b1, 32'h20, 1'b1);
        total++; if (ic_pc !== 32'h18 || dq_pred0 !== 1'b1) begin bad++; $display("FAIL bneg got=%h/%b want=18/1", ic_pc, dq_pred0); end
        redir(1'b1, 32'h20, 1'b0, 32'h0);
        drive(1'b1, enc_b(13'h0008), 2'd0, 1'b1, 32'h20, 1'b0);
        total++; if (ic_pc !== 32'h24 || dq_pred0 !== 1'b0 || dq_pc0 !== 32'h20) begin bad++; $display("FAIL bpos got=%h/%b/%h want=24/0/20", ic_pc, dq_pred0, dq_pc0); end
    endtask

    task automatic test_jalr_redirect();
        redir(1'b1, 32'h30, 1'b0, 32'h0);
        drive(1'b1, enc_jalr(), 2'd0, 1'b1, 32'h30, 1'b0);
        total++; if (ic_req !== 1'b0 || ic_pc !== 32'h34) begin bad++; $display("FAIL jalr_stall got=%b/%h want=0/34", ic_req, ic_pc); end
        drive(1'b1, enc_addi(12'd5), 2'd0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, enc_addi(12'd5), 2'd0, 1'b0, 32'h0, 1'b0);
        total++; if (s_req !== 1'b0 || ic_pc !== 32'h34 || dq_valid1 !== 1'b0) begin bad++; $display("FAIL jalr_hold got=%b/%h/%b want=0/34/0", s_req, ic_pc, dq_valid1); end
        redir(1'b0, 32'h0, 1'b1, 32'h400);
        total++; if (ic_pc !== 32'h400 || ic_req !== 1'b1 || dq_valid0 !== 1'b0) begin bad++; $display("FAIL jalr_resolve got=%h/%b/%b want=400/1/0", ic_pc, ic_req, dq_valid0); end
        drive(1'b1, enc_addi(12'd6), 2'd0, 1'b1, 32'h400, 1'b0);
        total++; if (dq_valid0 !== 1'b1 || dq_pc0 !== 32'h400) begin bad++; $display("FAIL redir_first got=%b/%h want=1/400", dq_valid0, dq_pc0); end
        redir(1'b1, 32'h80, 1'b1, 32'h90);
        total++; if (ic_pc !== 32'h80 || dq_valid0 !== 1'b0) begin bad++; $display("FAIL redir_prio got=%h/%b want=80/0", ic_pc, dq_valid0); end
    endtask

    // Random hits and issue widths against the scoreboard; stream of ADDI so the PC advances by 4.
    task automatic test_back_to_back();
        logic [31:0] m_pc;
        logic        hit, enq;
        logic [1:0]  iss;
        int          pop;
        redir(1'b1, 32'h1000, 1'b0, 32'h0);
        m_pc = 32'h1000;
        for (int k = 0; k < 60; k++) begin
            hit = ($urandom_range(0, 3) != 0);
            iss = 2'($urandom_range(0, 2));
            pop = (int'(iss) > sb.size()) ? sb.size() : int'(iss);
            enq = hit && ((sb.size() - pop) < 4);
            drive(hit, enc_addi(12'(k)), iss, enq, m_pc, 1'b0);
            total++; if (s_req !== ((sb.size() - (enq ? 1 : 0) + pop) - pop < 4)) begin bad++; $display("FAIL stream_req k=%0d got=%b", k, s_req); end
            if (enq) m_pc = m_pc + 32'd4;
            total++; if (ic_pc !== m_pc) begin bad++; $display("FAIL stream_pc k=%0d got=%h want=%h", k, ic_pc, m_pc); end
            total++; if (dq_valid0 !== (sb.size() >= 1) || dq_valid1 !== (sb.size() >= 2)) begin bad++; $display("FAIL stream_valid k=%0d got=%b%b size=%0d", k, dq_valid0, dq_valid1, sb.size()); end
            if (sb.size() >= 1) begin
                total++; if (dq_pc0 !== sb[0].pc || dq_inst0 !== sb[0].inst) begin bad++; $display("FAIL stream_e0 k=%0d got=%h/%h want=%h/%h", k, dq_pc0, dq_inst0, sb[0].pc, sb[0].inst); end
            end
            if (sb.size() >= 2) begin
                total++; if (dq_pc1 !== sb[1].pc || dq_inst1 !== sb[1].inst) begin bad++; $display("FAIL stream_e1 k=%0d got=%h/%h want=%h/%h", k, dq_pc1, dq_inst1, sb[1].pc, sb[1].inst); end
            end
        end
    endtask

    task automatic test_freeze_reset();
        redir(1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, enc_addi(12'(i)), 2'd0, 1'b1, 32'(4*i), 1'b0);
        rdy = 1'b0; ic_hit = 1'b1; issue_cnt = 2'd2; ic_inst = bswap(enc_addi(12'd8));
        repeat (3) @(posedge clk);
        #1;
        total++; if (ic_req !== 1'b0 || ic_pc !== 32'hC) begin bad++; $display("FAIL freeze_pc got=%b/%h want=0/c", ic_req, ic_pc); end
        total++; if (dq_valid1 !== 1'b1 || dq_pc0 !== 32'h0 || dq_pc1 !== 32'h4) begin bad++; $display("FAIL freeze_q got=%b/%h/%h want=1/0/4", dq_valid1, dq_pc0, dq_pc1); end
        rdy = 1'b1; ic_hit = 1'b0; issue_cnt = 2'd0;
        #1;
        total++; if (ic_req !== 1'b1) begin bad++; $display("FAIL freeze_resume got=%b want=1", ic_req); end
        rst_n = 1'b0;
        #1;
        total++; if (dq_valid0 !== 1'b0 || ic_pc !== 32'h0) begin bad++; $display("FAIL async_reset got=%b/%h want=0/0", dq_valid0, ic_pc); end
        #1 rst_n = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        drive(1'b1, enc_addi(12'd4), 2'd0, 1'b1, 32'h0, 1'b0);
        total++; if (s_req !== 1'b1 || s_pc !== 32'h0 || dq_pc0 !== 32'h0 || dq_valid0 !== 1'b1) begin bad++; $display("FAIL reset_refetch got=%b/%h/%h want=1/0/0", s_req, s_pc, dq_pc0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_predict();
        test_jalr_redirect();
        test_back_to_back();
        test_freeze_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cpu_fetch_q.md
# cpu_fetch_q

Parametrised instruction-fetch unit with a decoupling fetch queue. It sits between the instruction cache and the dual-issue decoder. The unit fetches one word per cycle into a QDEPTH-entry circular queue and applies static prediction: JAL is always taken, and a B-type branch is taken when its offset is negative. It stalls on JALR, and it flushes and redirects on branch or jump resolution. The decoder can drain 0, 1 or 2 queue entries per cycle.

## Interface
- ADDR_W, 32, PC and address width
- QDEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC loaded at reset

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- ic_req  out  1  fetch request; equals rdy & ~jalr_stall & ~q_full_eff
- ic_pc  out  ADDR_W  fetch address (current fetch PC register)
- ic_hit  in  1  same-cycle hit for ic_pc
- ic_inst  in  32  raw word, byte-reversed; the unit swaps to {b0,b1,b2,b3} order
- br_valid / br_pc  in  1 / ADDR_W  branch-unit redirect (mispredict)
- jmp_valid / jmp_pc  in  1 / ADDR_W  ALU jump redirect (JALR resolution)
- dq_valid0, dq_valid1  out  1  head and head+1 entries valid
- dq_pc0, dq_pc1  out  ADDR_W  entry PCs
- dq_inst0, dq_inst1  out  32  byte-swapped instructions
- dq_pred0, dq_pred1  out  1  predicted-taken flag
- issue_cnt  in  2  entries consumed this cycle (0/1/2)

## Operation
- **Queue storage:**
  - Entries are {pc, inst, pred}.
  - The queue is addressed by head and tail pointers of log2(QDEPTH) bits that wrap modulo QDEPTH.
  - A count register of log2(QDEPTH)+1 bits tracks occupancy.
  - dq_* are driven combinationally from registered entries at head and head+1.
  - dq_valid0 = count≥1; dq_valid1 = count≥2.
- **Pop:**
  - pop = issue_cnt, gated by rdy.
  - issue_cnt > count is illegal; the unit treats it as count (saturated).
- **q_full_eff:** (count − pop) == QDEPTH. Same-cycle pops free space for an enqueue.
- **Enqueue:** one entry when ic_req & ic_hit & no redirect. Decode the swapped word (opcode = inst[6:0]):
  - **JAL (1101111):** pred=1; next PC = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - **B-type (1100011):** offset = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
    - pred = inst[31]. Next PC = pc + offset if pred, else pc + 4.
  - **JALR (1100111, funct3=000):** pred=0; next PC = pc + 4; set jalr_stall.
  - **Other:** pred=0; next PC = pc + 4.
- **Miss:** with ic_hit=0, PC holds and ic_req stays asserted; nothing is enqueued.
- **jalr_stall:** while set, ic_req=0. It clears only on a redirect.
- **Redirect:**
  - br_valid has priority over jmp_valid.
  - On a redirect: PC ← target, queue flushed (head=tail=count=0), jalr_stall ← 0.
  - Any same-cycle enqueue and pop are discarded. Outputs show empty the next cycle.
- **rdy=0:** no PC, queue or stall update. Redirect inputs are ignored, and sources must hold them until rdy=1.
- **PC arithmetic:** modulo 2^ADDR_W; wrap is not flagged.

## Timing
- **Reset (async, rst_n=0):**
  - PC=RESET_PC, count=0, head=tail=0, jalr_stall=0.
  - dq_valid0/1=0; dq_pc/inst/pred entries are zero.
  - ic_req = rdy.
- **Fetch to decoder:** a word fetched on a hit in cycle N is visible on dq_*0 in cycle N+1 if the queue was empty.
- **Throughput:** one enqueue per cycle; up to two pops per cycle.
- **Redirect latency:** redirect asserted in cycle N gives ic_pc=target in cycle N+1, and the first redirected instruction appears on dq at N+2 on a hit.
- **Reset mid-operation:** immediate return to reset state regardless of clk; the first fetch is at RESET_PC.

## Test plan
- **Reset and basic fetch:** rst_n pulse, then hits with ADDI words at 0,4,8 and issue_cnt=0 → dq_pc0=0, dq_valid1=1 after 2 cycles, count=3.
- **Full queue:**
  - QDEPTH=4 with no issue → after 4 hits ic_req=0 and ic_pc=0x10.
  - Then issue_cnt=1 → the same cycle enqueues 0x10 and count stays 4.
- **JAL prediction:** JAL imm=+0x100 at pc 0x8 → next ic_pc=0x108, dq_pred=1 for the 0x8 entry.
- **Branch prediction:**
  - BEQ offset −8 at 0x20 → next ic_pc=0x18, pred=1.
  - BEQ offset +8 at 0x20 → next ic_pc=0x24, pred=0.
- **JALR and simultaneous redirects:**
  - JALR at 0x30 → ic_req=0 until jmp_valid with jmp_pc=0x400, then ic_pc=0x400.
  - br_valid and jmp_valid together (br_pc=0x80, jmp_pc=0x90) → ic_pc=0x80, queue empty.
- **Freeze and async reset:**
  - rdy=0 for 3 cycles with hits and issue_cnt=2 → count, PC and outputs unchanged.
  - rst_n low mid-stream → dq_valid0=0 asynchronously.
